bcd_serial_add_ctrl: RTL and testbench

BCD_SERIAL_ADD_CTRL -- requirements
Module: bcd_serial_add_ctrl

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_ripple_adder.sv | 23 ++
 rtl/bcd_serial_add_ctrl.sv | 141 ++++++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants for the serial BCD adder: digit geometry, decimal correction, FSM encoding.
package bcd_pkg;

    localparam int unsigned DIGIT_W  = 4;
    localparam int unsigned SUM_W    = DIGIT_W + 1;
    localparam int unsigned STATE_W  = 2;

    localparam logic [DIGIT_W-1:0] BCD_MAX  = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_CORR = 4'd6;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_ADD  = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

    function automatic logic digit_illegal(input logic [DIGIT_W-1:0] d);
        return d > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_ripple_adder.sv
// Single-digit BCD adder: binary add of two digits plus carry, then +6 correction above 9.
module bcd_ripple_adder
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a_i,
    input  logic [DIGIT_W-1:0] b_i,
    input  logic               cin_i,
    output logic [DIGIT_W-1:0] sum_c,
    output logic               cout_c
);

    logic [SUM_W-1:0] bin_sum;
    logic [SUM_W-1:0] corr_sum;

    // Five bits hold any pair of nibbles plus carry, even for non-BCD digits.
    always_comb begin
        bin_sum  = SUM_W'(a_i) + SUM_W'(b_i) + SUM_W'(cin_i);
        cout_c   = bin_sum > SUM_W'(BCD_MAX);
        corr_sum = bin_sum + SUM_W'(BCD_CORR);
        sum_c    = cout_c ? corr_sum[DIGIT_W-1:0] : bin_sum[DIGIT_W-1:0];
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial multi-digit BCD adder: captures operands, adds one digit per cycle through a
// single shared digit adder, then pulses done with the packed sum and final carry.
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DIGITS*DIGIT_W-1:0] op_a,
    input  logic [DIGITS*DIGIT_W-1:0] op_b,
    input  logic                      cin,
    output logic                      busy,
    output logic                      done,
    output logic [DIGITS*DIGIT_W-1:0] sum,
    output logic                      cout,
    output logic                      err
);

    localparam int unsigned OP_W  = DIGITS * DIGIT_W;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [OP_W-1:0]    a_q,     a_d;
    logic [OP_W-1:0]    b_q,     b_d;
    logic [OP_W-1:0]    sum_q,   sum_d;
    logic               carry_q, carry_d;
    logic               cout_q,  cout_d;
    logic               err_q,   err_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;

    logic [DIGIT_W-1:0] dig_a_c;
    logic [DIGIT_W-1:0] dig_b_c;
    logic [DIGIT_W-1:0] dig_sum_c;
    logic               dig_cout_c;
    logic               operand_err_c;

    assign dig_a_c = a_q[32'(idx_q) * DIGIT_W +: DIGIT_W];
    assign dig_b_c = b_q[32'(idx_q) * DIGIT_W +: DIGIT_W];

    bcd_ripple_adder u_digit_add (
        .a_i    (dig_a_c),
        .b_i    (dig_b_c),
        .cin_i  (carry_q),
        .sum_c  (dig_sum_c),
        .cout_c (dig_cout_c)
    );

    // Flag any non-BCD nibble in the operands presented at capture.
    always_comb begin
        operand_err_c = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (digit_illegal(op_a[i*DIGIT_W +: DIGIT_W]) ||
                digit_illegal(op_b[i*DIGIT_W +: DIGIT_W])) begin
                operand_err_c = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    err_d   = operand_err_c;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                sum_d[32'(idx_q) * DIGIT_W +: DIGIT_W] = dig_sum_c;
                carry_d = dig_cout_c;
                // cout is loaded on entry to DONE so it is valid alongside the done pulse.
                if (idx_q == IDX_LAST) begin
                    cout_d  = dig_cout_c;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Scoreboard bench for bcd_serial_add_ctrl (DIGITS=4): directed operations queue their
// expected result and done cycle; a negedge monitor checks each done pulse against the queue.
module tb_bcd_serial_add_ctrl;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = DIGITS * 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
        logic         chk_sum;
        int unsigned  cyc;
        string        tag;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc;
    int          n_cmp;
    int          n_bad;

    bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Wait for idle, present operands for one edge, then scramble them to prove they are not re-read.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic [W-1:0] esum, input logic ecout, input logic eerr,
                         input logic chk, input logic push, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) check({tag, " idle_timeout"}, 32'(busy), 32'd0);
        op_a  = a;
        op_b  = b;
        cin   = ci;
        start = 1'b1;
        if (push) sb_q.push_back('{esum, ecout, eerr, chk, cyc + 1 + DIGITS, tag});
        @(negedge clk);
        start = 1'b0;
        op_a  = W'($urandom);
        op_b  = W'($urandom);
        cin   = 1'($urandom);
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.tag, " done_cycle"}, cyc, e.cyc);
                check({e.tag, " err"}, 32'(err), 32'(e.err));
                if (e.chk_sum) begin
                    check({e.tag, " sum"}, 32'(sum), 32'(e.sum));
                    check({e.tag, " cout"}, 32'(cout), 32'(e.cout));
                end
            end
        end
    end

    initial begin
        int n;
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset sum",  32'(sum),  32'd0);
        check("reset cout", 32'(cout), 32'd0);
        check("reset err",  32'(err),  32'd0);
        rst = 1'b0;

        issue(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b1, 1'b1, "add1234_5678");
        check("busy_after_capture", 32'(busy), 32'd1);
        issue(16'h4567, 16'h5433, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b1, "add4567_5433_c1");
        issue(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, "add0_0_c1");
        issue(16'h0500, 16'h0500, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1, 1'b1, "b2b0500_0500");

        // Extra start pulses with other operands while the first operation is running.
        issue(16'h2345, 16'h1111, 1'b0, 16'h3456, 1'b0, 1'b0, 1'b1, 1'b1, "ignore_restart");
        repeat (4) begin
            op_a  = 16'h9999;
            op_b  = 16'h9999;
            cin   = 1'b1;
            start = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;

        issue(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, "ripple9999_0001");

        // Abort mid-operation; this operation must never report done.
        issue(16'h11A1, 16'h2222, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, "aborted");
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort sum",  32'(sum),  32'd0);
        check("abort cout", 32'(cout), 32'd0);
        check("abort err",  32'(err),  32'd0);
        @(negedge clk);
        rst   = 1'b0;
        op_a  = 16'h0042;
        op_b  = 16'h0058;
        cin   = 1'b0;
        start = 1'b1;
        sb_q.push_back('{16'h0100, 1'b0, 1'b0, 1'b1, cyc + 1 + DIGITS, "post_reset0042_0058"});
        @(negedge clk);
        start = 1'b0;
        check("post_reset busy", 32'(busy), 32'd1);

        issue(16'h12A4, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, "illegal12A4");
        check("illegal err_after_capture", 32'(err), 32'd1);

        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        while (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check({e.tag, " done_missing"}, 32'd0, 32'd1);
        end
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
